// File: rtl/mult6_scheduler.sv
// Two-requester round-robin front end sharing one iterative shift-add multiplier.
// Ports: clk/rstn, req{0,1}_{valid,ready,a,b} in, res_{valid,ready,data,id} out, busy.
module mult6_scheduler #(
  parameter int W = 6
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_data,
  output logic           res_id,
  output logic           busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_last;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_id;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_res_data;
  logic           r_res_id;

  logic           w_idle;
  logic           w_grant0;
  logic           w_grant1;
  logic           w_accept;
  logic           w_last_bit;
  logic [2*W-1:0] w_addend;
  logic [2*W-1:0] w_sum;

  // r_last is the requester served most recently; the other one wins a tie.
  assign w_grant0 = req0_valid & (~req1_valid | r_last);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last);

  // rstn gates ready so nothing looks accepted while reset is held.
  assign w_idle     = (r_state == IDLE) & rstn;
  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;
  assign w_accept   = req0_ready | req1_ready;

  assign w_last_bit = (r_cnt == CW'(W - 1));
  assign w_addend   = r_b[r_cnt] ? ({{W{1'b0}}, r_a} << r_cnt) : '0;
  assign w_sum      = r_acc + w_addend;

  assign res_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == IDLE): if (w_accept)   w_next = MUL;
      (r_state == MUL):  if (w_last_bit) w_next = DONE;
      (r_state == DONE): if (res_ready)  w_next = IDLE;
      default:                           w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_a        <= '0;
      r_b        <= '0;
      r_id       <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_res_data <= '0;
      r_res_id   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a    <= req1_ready ? req1_a : req0_a;
        r_b    <= req1_ready ? req1_b : req0_b;
        r_id   <= req1_ready;
        r_last <= req1_ready;
        r_acc  <= '0;
        r_cnt  <= '0;
      end
      if (r_state == MUL) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CW'(1);
        // The published result only changes when a product completes.
        if (w_last_bit) begin
          r_res_data <= w_sum;
          r_res_id   <= r_id;
        end
      end
    end
  end

endmodule
